tb_ethernet_frame_scheduler: RTL and testbench

Testbench-side scheduler that drives the fake Ethernet byte-stream transmitter. It queues ARP, ICMP and UDP send requests from up to three independent requesters and grants them round-robin. It issues the one-cycle start pulse and message type to the transmitter, tracks the resulting byte burst until the frame ends, and enforces an inter-frame gap before the next grant. It also reports frame counts, last frame length and error flags to the bench.

---
 rtl/tb_ethernet_frame_scheduler.sv | 190 +++++++++++++++++++
 tb/tb_tb_ethernet_frame_scheduler.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/tb_ethernet_frame_scheduler.sv
// Round-robin scheduler for ARP/ICMP/UDP frames on the fake Ethernet transmitter.
// It queues requests per type, issues start pulses, tracks each burst and enforces the inter-frame gap.
module tb_ethernet_frame_scheduler #(
  parameter int IFG_CYCLES    = 12,
  parameter int START_TIMEOUT = 8,
  parameter int CNT_W         = 4
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [2:0]  i_req,
  input  logic        i_enable,
  input  logic        i_clr_status,
  input  logic        i_tx_valid,
  output logic        o_start_send,
  output logic [1:0]  o_msg_type,
  output logic        o_busy,
  output logic [15:0] o_frames_sent,
  output logic [7:0]  o_last_len,
  output logic        o_timeout_err,
  output logic        o_overflow,
  output logic [2:0]  o_pending
);

  typedef enum logic [2:0] {S_IDLE, S_START, S_WAIT_VALID, S_SEND, S_GAP} state_e;

  localparam int TMR_MAX = (IFG_CYCLES > START_TIMEOUT) ? IFG_CYCLES : START_TIMEOUT;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam logic [TMR_W-1:0] TMO_LAST = TMR_W'(START_TIMEOUT - 1);
  localparam logic [TMR_W-1:0] IFG_LAST = TMR_W'(IFG_CYCLES - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q [3];
  logic [CNT_W-1:0] cnt_d [3];
  logic [1:0]       rr_ptr_q, rr_ptr_d;
  logic [1:0]       grant_q, grant_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [7:0]       len_q, len_d;
  logic             start_q, start_d;
  logic [1:0]       msg_q, msg_d;
  logic             busy_q, busy_d;
  logic [15:0]      frames_q, frames_d;
  logic [7:0]       last_len_q, last_len_d;
  logic             to_err_q, to_err_d;
  logic             ovf_q, ovf_d;

  logic [2:0] pend;
  logic [3:0] pend4;
  logic [1:0] order [3];
  logic [1:0] win;
  logic       win_ok;
  logic [2:0] dec;
  logic       ovf_set, to_set, frame_done;

  always_comb begin
    for (int b = 0; b < 3; b++) pend[b] = (cnt_q[b] != '0);
  end
  assign pend4 = {1'b0, pend};

  always_comb begin
    // NOTE: every _d and helper gets a default first, so no path through this block can infer a latch.
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    grant_d    = grant_q;
    timer_d    = timer_q;
    len_d      = len_q;
    start_d    = 1'b0;
    msg_d      = 2'b00;
    last_len_d = last_len_q;
    ovf_set    = 1'b0;
    to_set     = 1'b0;
    frame_done = 1'b0;
    win        = 2'd0;
    win_ok     = 1'b0;
    for (int b = 0; b < 3; b++) cnt_d[b] = cnt_q[b];

    // Search starts just after the last granted type.
    unique case (rr_ptr_q)
      2'd0:    begin order[0] = 2'd1; order[1] = 2'd2; order[2] = 2'd0; end
      2'd1:    begin order[0] = 2'd2; order[1] = 2'd0; order[2] = 2'd1; end
      default: begin order[0] = 2'd0; order[1] = 2'd1; order[2] = 2'd2; end
    endcase
    for (int k = 0; k < 3; k++) begin
      if (!win_ok && pend4[order[k]]) begin
        win    = order[k];
        win_ok = 1'b1;
      end
    end

    dec = (state_q == S_START) ? (3'b001 << grant_q) : 3'b000;
    for (int b = 0; b < 3; b++) begin
      if (i_req[b] && !dec[b]) begin
        if (cnt_q[b] == {CNT_W{1'b1}}) ovf_set = 1'b1;
        else                           cnt_d[b] = cnt_q[b] + 1'b1;
      end else if (dec[b] && !i_req[b]) begin
        cnt_d[b] = cnt_q[b] - 1'b1;
      end
    end

    unique case (state_q)
      S_IDLE: begin
        if (i_enable && win_ok) begin
          grant_d  = win;
          rr_ptr_d = win;
          start_d  = 1'b1;
          msg_d    = win + 2'd1;
          state_d  = S_START;
        end
      end
      S_START: begin
        timer_d = '0;
        state_d = S_WAIT_VALID;
      end
      S_WAIT_VALID: begin
        if (i_tx_valid) begin
          len_d   = 8'd1;
          state_d = S_SEND;
        end else if (timer_q == TMO_LAST) begin
          to_set  = 1'b1;
          timer_d = '0;
          state_d = S_GAP;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_SEND: begin
        if (i_tx_valid) begin
          if (len_q != 8'hFF) len_d = len_q + 8'd1;
        end else begin
          last_len_d = len_q;
          frame_done = 1'b1;
          timer_d    = '0;
          state_d    = S_GAP;
        end
      end
      default: begin
        if (timer_q == IFG_LAST) state_d = S_IDLE;
        else                     timer_d = timer_q + 1'b1;
      end
    endcase

    busy_d   = (state_d != S_IDLE);
    // Set events take priority over a simultaneous clear.
    to_err_d = to_set  ? 1'b1 : (i_clr_status ? 1'b0 : to_err_q);
    ovf_d    = ovf_set ? 1'b1 : (i_clr_status ? 1'b0 : ovf_q);
    frames_d = frame_done ? frames_q + 16'd1 : (i_clr_status ? 16'd0 : frames_q);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q    <= S_IDLE;
      for (int b = 0; b < 3; b++) cnt_q[b] <= '0;
      rr_ptr_q   <= 2'd2;
      grant_q    <= 2'd0;
      timer_q    <= '0;
      len_q      <= 8'd0;
      start_q    <= 1'b0;
      msg_q      <= 2'b00;
      busy_q     <= 1'b0;
      frames_q   <= 16'd0;
      last_len_q <= 8'd0;
      to_err_q   <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      for (int b = 0; b < 3; b++) cnt_q[b] <= cnt_d[b];
      rr_ptr_q   <= rr_ptr_d;
      grant_q    <= grant_d;
      timer_q    <= timer_d;
      len_q      <= len_d;
      start_q    <= start_d;
      msg_q      <= msg_d;
      busy_q     <= busy_d;
      frames_q   <= frames_d;
      last_len_q <= last_len_d;
      to_err_q   <= to_err_d;
      ovf_q      <= ovf_d;
    end
  end

  assign o_start_send  = start_q;
  assign o_msg_type    = msg_q;
  assign o_busy        = busy_q;
  assign o_frames_sent = frames_q;
  assign o_last_len    = last_len_q;
  assign o_timeout_err = to_err_q;
  assign o_overflow    = ovf_q;
  assign o_pending     = pend;

endmodule

// File: tb/tb_tb_ethernet_frame_scheduler.sv
// Bench for the frame scheduler: a transmitter stand-in, a timestamp-based reference model
// checked every cycle, and directed scenarios pinned with hand-computed values.
module tb_tb_ethernet_frame_scheduler;
  localparam int IFG     = 12;
  localparam int TMO     = 8;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
  localparam longint INF = 64'h3fff_ffff_ffff_ffff;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  req = 3'b000;
  logic        en = 1'b0, clr = 1'b0, tx_valid = 1'b0;
  logic        o_start_send, o_busy, o_timeout_err, o_overflow;
  logic [1:0]  o_msg_type;
  logic [15:0] o_frames_sent;
  logic [7:0]  o_last_len;
  logic [2:0]  o_pending;
  bit          tx_mute = 1'b0;

  tb_ethernet_frame_scheduler #(.IFG_CYCLES(IFG), .START_TIMEOUT(TMO), .CNT_W(CNT_W)) dut (
    .i_clk(clk), .i_reset(rst), .i_req(req), .i_enable(en), .i_clr_status(clr),
    .i_tx_valid(tx_valid), .o_start_send(o_start_send), .o_msg_type(o_msg_type),
    .o_busy(o_busy), .o_frames_sent(o_frames_sent), .o_last_len(o_last_len),
    .o_timeout_err(o_timeout_err), .o_overflow(o_overflow), .o_pending(o_pending)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      if (n_bad <= 40) $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Transmitter stand-in: valid rises two edges after the start cycle, lasts 50 (ARP) or 82 bytes.
  initial begin
    int delay = 0, left = 0, blen = 0;
    forever begin
      @(posedge clk); #2;
      if (rst) begin
        delay = 0; left = 0; tx_valid = 1'b0;
      end else begin
        if (delay > 0) begin
          delay--;
          if (delay == 0) left = blen;
        end
        if (left > 0) begin tx_valid = 1'b1; left--; end
        else tx_valid = 1'b0;
        if (o_start_send && !tx_mute) begin
          delay = 2;
          blen  = (o_msg_type == 2'b01) ? 50 : 82;
        end
      end
    end
  end

  // Reference model: counters, pointer and timestamps for when the scheduler is free again.
  longint tick = 0;
  int     m_cnt [3];
  int     m_ptr = 2, m_type = 0, m_frames = 0, m_last = 0, burst = 0;
  bit     m_ovf = 0, m_to = 0, in_flight = 0, bursting = 0;
  longint idle_at = 0, start_at = -10;

  int     st_type [$];
  longint st_tick [$];
  int     len_log [$];
  longint busy_fall_tick = 0, err_tick = 0;
  logic   prev_busy = 0, prev_to = 0;
  logic [15:0] prev_frames = 0;

  task automatic model_step();
    longint prev_start;
    int     dec_type, c;
    bit     done, to_set, ovf_set, inc, dec;
    if (rst) begin
      m_cnt = '{0, 0, 0}; m_ptr = 2; m_ovf = 0; m_to = 0; m_frames = 0; m_last = 0;
      idle_at = tick; start_at = -10; in_flight = 0; bursting = 0; burst = 0;
      return;
    end
    prev_start = start_at; dec_type = m_type;
    done = 0; to_set = 0; ovf_set = 0;
    if (tick - 1 >= idle_at && en && (m_cnt[0] + m_cnt[1] + m_cnt[2]) > 0) begin
      for (int k = 3; k >= 1; k--) begin
        c = (m_ptr + k) % 3;
        if (m_cnt[c] > 0) m_type = c;
      end
      m_ptr = m_type; start_at = tick; idle_at = INF; in_flight = 1; bursting = 0;
    end
    if (in_flight && tick >= start_at + 2) begin
      if (!bursting) begin
        if (tx_valid) begin bursting = 1; burst = 1; end
        else if (tick == start_at + TMO + 1) begin to_set = 1; in_flight = 0; idle_at = tick + IFG; end
      end else if (tx_valid) begin
        burst = (burst < 255) ? burst + 1 : 255;
      end else begin
        done = 1; m_last = burst; in_flight = 0; idle_at = tick + IFG;
      end
    end
    for (int b = 0; b < 3; b++) begin
      inc = req[b];
      dec = (prev_start == tick - 1) && (dec_type == b);
      if (inc && !dec) begin
        if (m_cnt[b] == CNT_MAX) ovf_set = 1; else m_cnt[b]++;
      end else if (dec && !inc) m_cnt[b]--;
    end
    m_ovf    = ovf_set ? 1'b1 : (clr ? 1'b0 : m_ovf);
    m_to     = to_set  ? 1'b1 : (clr ? 1'b0 : m_to);
    m_frames = done ? (m_frames + 1) % 65536 : (clr ? 0 : m_frames);
  endtask

  initial begin
    forever begin
      @(posedge clk); #1;
      tick++;
      model_step();
      check("start_send", o_start_send, (!rst && start_at == tick));
      check("msg_type",   o_msg_type,   (!rst && start_at == tick) ? m_type + 1 : 0);
      check("busy",       o_busy,       (!rst && tick < idle_at));
      check("frames",     o_frames_sent, m_frames);
      check("last_len",   o_last_len,   m_last);
      check("timeout",    o_timeout_err, m_to);
      check("overflow",   o_overflow,   m_ovf);
      check("pending",    o_pending,    {m_cnt[2] > 0, m_cnt[1] > 0, m_cnt[0] > 0});
      if (o_start_send) begin st_type.push_back(o_msg_type); st_tick.push_back(tick); end
      if (prev_busy && !o_busy) busy_fall_tick = tick;
      if (o_timeout_err && !prev_to) err_tick = tick;
      if (!rst && o_frames_sent == prev_frames + 16'd1) len_log.push_back(o_last_len);
      prev_busy = o_busy; prev_to = o_timeout_err; prev_frames = o_frames_sent;
    end
  end

  task automatic do_reset();
    req = 3'b000; clr = 1'b0; tx_mute = 1'b0; rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    st_type.delete(); st_tick.delete(); len_log.delete();
  endtask

  task automatic pulse(input logic [2:0] v);
    req = v; @(negedge clk); req = 3'b000;
  endtask

  task automatic wait_quiet(input int budget, input string name);
    int n = 0;
    while ((o_busy || o_pending != 3'b000) && n < budget) begin @(negedge clk); n++; end
    check({"quiet_", name}, (n < budget), 1);
  endtask

  task automatic wait_starts(input int cnt, input int budget, input string name);
    int n = 0;
    while (st_type.size() < cnt && n < budget) begin @(negedge clk); n++; end
    check({"start_", name}, (n < budget), 1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    @(negedge clk); @(negedge clk);
    check("reset_busy", o_busy, 0);
    check("reset_start", o_start_send, 0);
    do_reset();

    // Single ARP
    en = 1'b1;
    pulse(3'b001);
    wait_quiet(500, "arp");
    check("arp_starts", st_type.size(), 1);
    check("arp_type", st_type[0], 1);
    check("arp_len", o_last_len, 50);
    check("arp_frames", o_frames_sent, 1);
    check("arp_busy_fall", busy_fall_tick - st_tick[0], 50 + IFG + 3);

    // All three in one cycle
    do_reset(); en = 1'b1;
    pulse(3'b111);
    wait_quiet(1000, "all3");
    check("all3_starts", st_type.size(), 3);
    check("all3_t0", st_type[0], 1);
    check("all3_t1", st_type[1], 2);
    check("all3_t2", st_type[2], 3);
    check("all3_l0", len_log[0], 50);
    check("all3_l1", len_log[1], 82);
    check("all3_l2", len_log[2], 82);
    check("all3_frames", o_frames_sent, 3);
    check("all3_gap01", st_tick[1] - st_tick[0], 50 + IFG + 4);
    check("all3_gap12", st_tick[2] - st_tick[1], 82 + IFG + 4);

    // Fairness
    do_reset(); en = 1'b0;
    pulse(3'b010); pulse(3'b010); pulse(3'b010); pulse(3'b100);
    en = 1'b1;
    wait_starts(1, 20, "fair");
    repeat (20) @(negedge clk);
    pulse(3'b001);
    wait_quiet(2000, "fair");
    check("fair_starts", st_type.size(), 5);
    check("fair_t0", st_type[0], 2);
    check("fair_t1", st_type[1], 3);
    check("fair_t2", st_type[2], 1);
    check("fair_t3", st_type[3], 2);
    check("fair_t4", st_type[4], 2);

    // Overflow
    do_reset(); en = 1'b0;
    repeat (17) pulse(3'b100);
    check("ovf_pending", o_pending, 3'b100);
    check("ovf_flag", o_overflow, 1);
    en = 1'b1;
    wait_quiet(3000, "ovf");
    check("ovf_frames", o_frames_sent, 15);
    check("ovf_starts", st_type.size(), 15);
    n = 0;
    foreach (st_type[i]) if (st_type[i] == 3) n++;
    check("ovf_udp", n, 15);
    clr = 1'b1; @(negedge clk); clr = 1'b0; @(negedge clk);
    check("ovf_cleared", o_overflow, 0);
    check("frames_cleared", o_frames_sent, 0);

    // Timeout
    do_reset(); en = 1'b1; tx_mute = 1'b1;
    pulse(3'b001); pulse(3'b010);
    wait_starts(1, 20, "to");
    @(negedge clk); tx_mute = 1'b0;
    n = 0;
    while (!o_timeout_err && n < 40) begin @(negedge clk); n++; end
    check("to_seen", o_timeout_err, 1);
    check("to_delay", err_tick - st_tick[0], TMO + 1);
    check("to_frames", o_frames_sent, 0);
    wait_quiet(1000, "to");
    check("to_starts", st_type.size(), 2);
    check("to_next_type", st_type[1], 2);
    check("to_frames2", o_frames_sent, 1);
    check("to_len", o_last_len, 82);

    // Reset in the middle of a burst
    do_reset(); en = 1'b1;
    pulse(3'b010);
    wait_starts(1, 20, "rst");
    repeat (30) @(negedge clk);
    pulse(3'b100);
    check("rst_busy_before", o_busy, 1);
    do_reset();
    check("rst_pending", o_pending, 0);
    check("rst_frames", o_frames_sent, 0);
    check("rst_busy", o_busy, 0);
    check("rst_len", o_last_len, 0);
    pulse(3'b001);
    wait_quiet(500, "rst");
    check("rst_arp_len", o_last_len, 50);
    check("rst_arp_frames", o_frames_sent, 1);

    // Random traffic checked cycle by cycle against the model
    do_reset(); en = 1'b1;
    for (int c = 0; c < 4000; c++) begin
      for (int b = 0; b < 3; b++) req[b] = ($urandom_range(0, 99) < 2);
      if ($urandom_range(0, 49) == 0) en = ~en;
      clr = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 299) == 0) tx_mute = ~tx_mute;
      rst = ($urandom_range(0, 1999) == 0);
      @(negedge clk);
    end
    req = 3'b000; clr = 1'b0; rst = 1'b0; tx_mute = 1'b0; en = 1'b1;
    wait_quiet(6000, "random");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
